// File: rtl/nbody_pkg.sv
// Shared N-body sequencer definitions: default sizing, body index type and
// the timestep FSM state encoding used by the sequencer and its consumers.
package nbody_pkg;

    localparam int unsigned DEFAULT_BODIES = 512;
    localparam int unsigned DEFAULT_IDX_W  = $clog2(DEFAULT_BODIES);

    typedef logic [DEFAULT_IDX_W-1:0] body_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEL,
        S_ACC_WAIT,
        S_UPDATE,
        S_LF_WAIT,
        S_STEP_END
    } nbody_state_t;

endpackage

// File: rtl/nbody_pair_gen.sv
// (i, j) body-pair generator for the acceleration phase: i outer, j inner,
// advancing only on handshake. NBODY_SKIP_SELF_EN drops the i == j pairs.
module nbody_pair_gen
    import nbody_pkg::*;
#(
    parameter int unsigned IDX_W = DEFAULT_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             advance,
    input  logic [IDX_W:0]   n,
    output logic [IDX_W-1:0] pair_i,
    output logic [IDX_W-1:0] pair_j,
    output logic             pair_last,
    output logic             pair_final
);

`ifdef NBODY_SKIP_SELF_EN
    localparam bit SKIP_SELF = 1'b1;
`else
    localparam bit SKIP_SELF = 1'b0;
`endif

    logic [IDX_W-1:0] n_m1;
    logic [IDX_W-1:0] last_j;
    logic [IDX_W-1:0] j_inc;

    assign n_m1 = IDX_W'(n - 1'b1);

    // The last row ends one early when its diagonal entry (j = n-1) is skipped.
    always_comb begin
        last_j = n_m1;
        if (SKIP_SELF && (pair_i == n_m1)) last_j = n_m1 - 1'b1;
        j_inc = pair_j + 1'b1;
        if (SKIP_SELF && (j_inc == pair_i)) j_inc = pair_j + 2'd2;
    end

    assign pair_last  = (pair_j == last_j);
    assign pair_final = pair_last && (pair_i == n_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_i <= '0;
            pair_j <= '0;
        end else if (init) begin
            pair_i <= '0;
            pair_j <= IDX_W'(SKIP_SELF);
        end else if (advance) begin
            if (pair_last) begin
                pair_i <= pair_i + 1'b1;
                pair_j <= '0;
            end else begin
                pair_j <= j_inc;
            end
        end
    end

endmodule

// File: rtl/nbody_step_sequencer.sv
// N-body timestep scheduler: per step, streams body pairs to the accel unit,
// then one leapfrog update per body. Build option: NBODY_SKIP_SELF_EN.
module nbody_step_sequencer
    import nbody_pkg::*;
#(
    parameter int unsigned BODIES = DEFAULT_BODIES,
    parameter int unsigned IDX_W  = $clog2(BODIES),
    parameter int unsigned STEP_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W:0]    num_bodies,
    input  logic [STEP_W-1:0] num_steps,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] steps_done,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [IDX_W-1:0]  pair_i,
    output logic [IDX_W-1:0]  pair_j,
    output logic              pair_last,
    input  logic              acc_done,
    output logic              lf_valid,
    input  logic              lf_ready,
    output logic [IDX_W-1:0]  lf_idx,
    input  logic              lf_done
);

    localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(BODIES);

    nbody_state_t      state, state_n;
    logic [IDX_W:0]    n_lat;
    logic [IDX_W:0]    acc_cnt;
    logic [IDX_W:0]    lf_cnt;
    logic [STEP_W-1:0] steps_lat;
    logic              range_ok;
    logic              run_last;
    logic              pair_fire;
    logic              pair_final;
    logic              lf_fire;
    logic              lf_last;
    logic              gen_init;

    assign range_ok  = (num_bodies >= (IDX_W+1)'(2)) && (num_bodies <= MAX_N);
    assign run_last  = ((steps_done + 1'b1) == steps_lat);
    assign pair_fire = pair_valid && pair_ready;
    assign lf_fire   = lf_valid && lf_ready;
    assign lf_last   = ({1'b0, lf_idx} == (n_lat - 1'b1));

    nbody_pair_gen #(
        .IDX_W (IDX_W)
    ) u_pair_gen (
        .clk        (clk),
        .rst        (rst),
        .init       (gen_init),
        .advance    (pair_fire),
        .n          (n_lat),
        .pair_i     (pair_i),
        .pair_j     (pair_j),
        .pair_last  (pair_last),
        .pair_final (pair_final)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        busy       = 1'b0;
        pair_valid = 1'b0;
        lf_valid   = 1'b0;
        gen_init   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && range_ok && (num_steps != '0)) begin
                    state_n  = S_ACCEL;
                    gen_init = 1'b1;
                end
            end
            S_ACCEL: begin
                busy       = 1'b1;
                pair_valid = 1'b1;
                if (pair_fire && pair_final) state_n = S_ACC_WAIT;
            end
            S_ACC_WAIT: begin
                busy = 1'b1;
                if (acc_cnt == n_lat) state_n = S_UPDATE;
            end
            S_UPDATE: begin
                busy     = 1'b1;
                lf_valid = 1'b1;
                if (lf_fire && lf_last) state_n = S_LF_WAIT;
            end
            S_LF_WAIT: begin
                busy = 1'b1;
                if (lf_cnt == n_lat) state_n = S_STEP_END;
            end
            S_STEP_END: begin
                busy = 1'b1;
                if (run_last) begin
                    state_n = S_IDLE;
                end else begin
                    state_n  = S_ACCEL;
                    gen_init = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // done/err are registered so they land in the cycle after the deciding state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_lat      <= '0;
            steps_lat  <= '0;
            steps_done <= '0;
            acc_cnt    <= '0;
            lf_cnt     <= '0;
            lf_idx     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if ((state == S_IDLE) && start) begin
                if (!range_ok) begin
                    err <= 1'b1;
                end else if (num_steps == '0) begin
                    done <= 1'b1;
                end else begin
                    n_lat      <= num_bodies;
                    steps_lat  <= num_steps;
                    steps_done <= '0;
                    acc_cnt    <= '0;
                    lf_cnt     <= '0;
                    lf_idx     <= '0;
                end
            end
            if (((state == S_ACCEL) || (state == S_ACC_WAIT)) && acc_done)
                acc_cnt <= acc_cnt + 1'b1;
            if (((state == S_UPDATE) || (state == S_LF_WAIT)) && lf_done)
                lf_cnt <= lf_cnt + 1'b1;
            if (lf_fire && !lf_last)
                lf_idx <= lf_idx + 1'b1;
            if (state == S_STEP_END) begin
                steps_done <= steps_done + 1'b1;
                done       <= run_last;
                acc_cnt    <= '0;
                lf_cnt     <= '0;
                lf_idx     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nbody_step_sequencer.sv
// Self-checking bench for nbody_step_sequencer: randomized handshakes checked
// against a pair-list / per-step reference model (honours NBODY_SKIP_SELF_EN).
module tb_nbody_step_sequencer;

    localparam int unsigned BODIES = 512;
    localparam int unsigned IDX_W  = 9;
    localparam int unsigned STEP_W = 32;
`ifdef NBODY_SKIP_SELF_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [IDX_W:0]    num_bodies = '0;
    logic [STEP_W-1:0] num_steps = '0;
    logic              busy, done, err;
    logic [STEP_W-1:0] steps_done;
    logic              pair_valid, pair_last, lf_valid;
    logic              pair_ready = 1'b0;
    logic              lf_ready = 1'b0;
    logic              acc_done = 1'b0;
    logic              lf_done = 1'b0;
    logic [IDX_W-1:0]  pair_i, pair_j, lf_idx;

    nbody_step_sequencer #(
        .BODIES (BODIES),
        .IDX_W  (IDX_W),
        .STEP_W (STEP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_bodies (num_bodies),
        .num_steps  (num_steps),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .steps_done (steps_done),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_i     (pair_i),
        .pair_j     (pair_j),
        .pair_last  (pair_last),
        .acc_done   (acc_done),
        .lf_valid   (lf_valid),
        .lf_ready   (lf_ready),
        .lf_idx     (lf_idx),
        .lf_done    (lf_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned i;
        int unsigned j;
        bit          last;
    } pair_t;

    int          checks = 0;
    int          failures = 0;
    pair_t       exp_q[$];
    int unsigned steps_hist[$];
    int unsigned pairs_seen, pair_errs, stall_errs, lf_seen, lf_errs;
    int unsigned done_cnt, err_cnt, busy_err, early_lf_err, done_steps;
    bit          timed_out;
    int unsigned model_steps = 0;

    function automatic int unsigned pairs_per_step(input int unsigned n);
        return SKIP ? n * (n - 1) : n * n;
    endfunction

    // Reference order: every (i, j), i outer, minus the diagonal when skipping.
    task automatic build_pairs(input int unsigned n);
        exp_q.delete();
        for (int unsigned i = 0; i < n; i++)
            for (int unsigned j = 0; j < n; j++)
                if (!(SKIP && i == j)) exp_q.push_back('{i: i, j: j, last: 1'b0});
        for (int k = 0; k < exp_q.size(); k++)
            exp_q[k].last = (k == exp_q.size() - 1) || (exp_q[k+1].i != exp_q[k].i);
    endtask

    task automatic do_start(input int unsigned n, input int unsigned s);
        start      = 1'b1;
        num_bodies = (IDX_W+1)'(n);
        num_steps  = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Plays the accel and leapfrog units and records what the DUT did.
    task automatic run_engine(input int unsigned n, input bit rand_ready, input bit early_acc,
                              input int inject_cyc, input bit stop_at_update,
                              input int unsigned budget);
        pair_t             e;
        int unsigned       acc_sent = 0;
        int unsigned       lf_next = 0;
        bit                stalled = 1'b0;
        bit                lf_stalled = 1'b0;
        bit                finished = 1'b0;
        logic [IDX_W-1:0]  s_i = '0, s_j = '0, s_lidx = '0;
        logic              s_last = 1'b0;
        logic [STEP_W-1:0] last_steps = '0;
        int unsigned       acc_sched[$];
        int unsigned       lf_sched[$];
        pairs_seen = 0; pair_errs = 0; stall_errs = 0; lf_seen = 0; lf_errs = 0;
        done_cnt = 0; err_cnt = 0; busy_err = 0; early_lf_err = 0; done_steps = 0;
        steps_hist.delete();
        build_pairs(n);
        for (int unsigned c = 0; c < budget && !finished; c++) begin
            acc_done = 1'b0; lf_done = 1'b0; start = 1'b0;
            if (lf_valid && acc_sent < n) early_lf_err++;
            if (steps_done != last_steps) begin
                last_steps = steps_done;
                steps_hist.push_back(steps_done);
                if (exp_q.size() != 0) pair_errs++;
                if (lf_next != n) lf_errs++;
                build_pairs(n);
                acc_sent = 0;
                lf_next  = 0;
            end
            if (done) begin
                done_cnt++;
                done_steps = steps_done;
                if (busy) busy_err++;
                finished = 1'b1;
            end
            if (err) err_cnt++;
            if (int'(c) == inject_cyc) begin
                start = 1'b1; num_bodies = 5; num_steps = 1;
            end
            if (acc_sched.size() != 0 && acc_sched[0] == c) begin
                void'(acc_sched.pop_front()); acc_done = 1'b1; acc_sent++;
            end
            if (lf_sched.size() != 0 && lf_sched[0] == c) begin
                void'(lf_sched.pop_front()); lf_done = 1'b1;
            end
            if (stalled && (pair_valid !== 1'b1 || pair_i !== s_i || pair_j !== s_j ||
                            pair_last !== s_last)) stall_errs++;
            pair_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = 1'b0;
            if (pair_valid) begin
                if (pair_ready) begin
                    pairs_seen++;
                    if (exp_q.size() == 0) begin
                        pair_errs++;
                    end else begin
                        e = exp_q.pop_front();
                        if (32'(pair_i) != e.i || 32'(pair_j) != e.j || pair_last !== e.last)
                            pair_errs++;
                        if (e.last && !(early_acc && e.i == 0)) acc_sched.push_back(c + 2);
                        if (early_acc && exp_q.size() == 0) begin
                            acc_done = 1'b1; acc_sent++;
                        end
                    end
                end else begin
                    stalled = 1'b1; s_i = pair_i; s_j = pair_j; s_last = pair_last;
                end
            end
            if (lf_stalled && (lf_valid !== 1'b1 || lf_idx !== s_lidx)) lf_errs++;
            lf_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            lf_stalled = 1'b0;
            if (lf_valid) begin
                if (lf_ready) begin
                    lf_seen++;
                    if (32'(lf_idx) != lf_next) lf_errs++;
                    lf_next++;
                    lf_sched.push_back(c + 1);
                end else begin
                    lf_stalled = 1'b1; s_lidx = lf_idx;
                end
            end
            if (stop_at_update && lf_valid) finished = 1'b1;
            if (!finished) begin
                @(posedge clk); #1;
            end
        end
        timed_out  = !finished;
        acc_done   = 1'b0; lf_done = 1'b0; start = 1'b0;
        pair_ready = 1'b0; lf_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, pair_valid, pair_last, lf_valid, steps_done, pair_i, pair_j, lf_idx} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b pv=%b lv=%b steps=%0d expected all 0",
                     busy, done, err, pair_valid, lf_valid, steps_done);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_step();
        do_start(4, 1);
        checks++;
        if ({busy, pair_valid} !== 2'b11 || pair_i !== '0 || pair_j !== IDX_W'(SKIP)) begin
            failures++;
            $display("FAIL start_latency: got busy=%b pv=%b i=%0d j=%0d expected 1 1 0 %0d",
                     busy, pair_valid, pair_i, pair_j, SKIP);
        end
        run_engine(4, 1'b0, 1'b0, -1, 1'b0, 2000);
        model_steps = 1;
        checks++;
        if (timed_out) begin failures++; $display("FAIL single_timeout: got timeout expected done"); end
        checks++;
        if (pairs_seen != pairs_per_step(4) || pair_errs != 0) begin
            failures++;
            $display("FAIL single_pairs: got %0d pairs (%0d errs) expected %0d", pairs_seen, pair_errs, pairs_per_step(4));
        end
        checks++;
        if (lf_seen != 4 || lf_errs != 0) begin
            failures++;
            $display("FAIL single_lf: got %0d updates (%0d errs) expected 4", lf_seen, lf_errs);
        end
        checks++;
        if (done_cnt != 1 || done_steps != 1 || busy_err != 0) begin
            failures++;
            $display("FAIL single_done: got done=%0d steps=%0d busy_err=%0d expected 1 1 0", done_cnt, done_steps, busy_err);
        end
        checks++;
        if (early_lf_err != 0) begin
            failures++;
            $display("FAIL single_order: got %0d early updates expected 0", early_lf_err);
        end
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 3; it++) begin
            int unsigned n = (it == 0) ? 4 : $urandom_range(2, 9);
            int unsigned s = (it == 0) ? 1 : $urandom_range(1, 2);
            do_start(n, s);
            run_engine(n, 1'b1, 1'b0, -1, 1'b0, 5000);
            model_steps = s;
            checks++;
            if (timed_out || pairs_seen != pairs_per_step(n) * s || pair_errs != 0) begin
                failures++;
                $display("FAIL bp_pairs n=%0d: got %0d pairs (%0d errs, to=%0b) expected %0d",
                         n, pairs_seen, pair_errs, timed_out, pairs_per_step(n) * s);
            end
            checks++;
            if (stall_errs != 0) begin
                failures++;
                $display("FAIL bp_stall n=%0d: got %0d unstable stalls expected 0", n, stall_errs);
            end
            checks++;
            if (lf_seen != n * s || lf_errs != 0 || done_cnt != 1 || done_steps != s) begin
                failures++;
                $display("FAIL bp_update n=%0d: got lf=%0d errs=%0d done=%0d steps=%0d expected %0d 0 1 %0d",
                         n, lf_seen, lf_errs, done_cnt, done_steps, n * s, s);
            end
        end
    endtask

    task automatic test_rejected();
        int unsigned bad_n[2];
        bad_n[0] = 1;
        bad_n[1] = BODIES + 1;
        for (int k = 0; k < 2; k++) begin
            do_start(bad_n[k], 3);
            checks++;
            if ({err, busy, done} !== 3'b100 || steps_done !== model_steps) begin
                failures++;
                $display("FAIL reject_n%0d: got err=%b busy=%b done=%b steps=%0d expected 1 0 0 %0d",
                         bad_n[k], err, busy, done, steps_done, model_steps);
            end
            @(posedge clk); #1;
            checks++;
            if ({err, busy} !== 2'b00) begin
                failures++;
                $display("FAIL reject_pulse_n%0d: got err=%b busy=%b expected 0 0", bad_n[k], err, busy);
            end
        end
        do_start(4, 0);
        checks++;
        if ({done, busy, err} !== 3'b100 || steps_done !== model_steps) begin
            failures++;
            $display("FAIL zero_steps: got done=%b busy=%b err=%b steps=%0d expected 1 0 0 %0d",
                     done, busy, err, steps_done, model_steps);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy, pair_valid} !== 3'b000) begin
            failures++;
            $display("FAIL zero_steps_after: got done=%b busy=%b pv=%b expected 0 0 0", done, busy, pair_valid);
        end
    endtask

    task automatic test_multi_step();
        int unsigned extra_done = 0;
        do_start(3, 3);
        run_engine(3, 1'b1, 1'b0, 5, 1'b0, 5000);
        model_steps = 3;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        checks++;
        if (timed_out || steps_hist.size() != 3) begin
            failures++;
            $display("FAIL multi_hist_len: got %0d step updates (to=%0b) expected 3", steps_hist.size(), timed_out);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (steps_hist[k] != k + 1) begin
                failures++;
                $display("FAIL multi_steps_%0d: got %0d expected %0d", k, steps_hist[k], k + 1);
            end
        end
        checks++;
        if (done_cnt + extra_done != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL multi_done: got done=%0d err=%0d expected 1 0", done_cnt + extra_done, err_cnt);
        end
        checks++;
        if (pairs_seen != 3 * pairs_per_step(3) || pair_errs != 0 || lf_errs != 0) begin
            failures++;
            $display("FAIL multi_pairs: got %0d pairs (%0d/%0d errs) expected %0d",
                     pairs_seen, pair_errs, lf_errs, 3 * pairs_per_step(3));
        end
    endtask

    task automatic test_reset_mid_run();
        do_start(4, 2);
        run_engine(4, 1'b0, 1'b0, -1, 1'b1, 2000);
        checks++;
        if (timed_out) begin failures++; $display("FAIL midrst_reach: got timeout expected UPDATE"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, pair_valid, pair_last, lf_valid, steps_done, pair_i, pair_j, lf_idx} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: got busy=%b pv=%b lv=%b i=%0d j=%0d lf=%0d expected all 0",
                     busy, pair_valid, lf_valid, pair_i, pair_j, lf_idx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_steps = 0;
        @(posedge clk); #1;
        do_start(5, 1);
        run_engine(5, 1'b0, 1'b0, -1, 1'b0, 2000);
        model_steps = 1;
        checks++;
        if (timed_out || pairs_seen != pairs_per_step(5) || pair_errs != 0 || lf_seen != 5 ||
            done_cnt != 1 || done_steps != 1) begin
            failures++;
            $display("FAIL midrst_rerun: got pairs=%0d errs=%0d lf=%0d done=%0d steps=%0d expected %0d 0 5 1 1",
                     pairs_seen, pair_errs, lf_seen, done_cnt, done_steps, pairs_per_step(5));
        end
    endtask

    task automatic test_early_acc();
        do_start(4, 1);
        run_engine(4, 1'b0, 1'b1, -1, 1'b0, 2000);
        model_steps = 1;
        checks++;
        if (timed_out || done_cnt != 1 || lf_seen != 4) begin
            failures++;
            $display("FAIL early_acc_done: got to=%0b done=%0d lf=%0d expected 0 1 4", timed_out, done_cnt, lf_seen);
        end
        checks++;
        if (early_lf_err != 0) begin
            failures++;
            $display("FAIL early_acc_order: got %0d early updates expected 0", early_lf_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_backpressure();
        test_rejected();
        test_multi_step();
        test_reset_mid_run();
        test_early_acc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
